// File: rtl/i_cache_control.sv
// -----------------------------------------------------------------------------
// i_cache_control
//
// Control FSM for a direct-mapped instruction cache. The datapath, which holds
// the valid/tag/data arrays, is outside this block. This block decides when to
// answer the CPU, when to request a line fill from main memory/L2, and when
// to load the returned line into the arrays.
//
// Optional build feature:
//   I_CACHE_PERF_CNT_EN - when defined, adds saturating hit/miss counters
//                         (hit_cnt, miss_cnt). When undefined, the ports and
//                         all counter logic are absent and the FSM is unchanged.
//
// Parameters:
//   CNT_W      width of the performance counters (feature build only)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   cpu_read   CPU fetch request, held high until cpu_resp
//   cpu_resp   one-cycle pulse: datapath cache_rdata is valid this cycle
//   hit        combinational tag match from the datapath
//   ld_v       load strobe for the valid array
//   ld_tag     load strobe for the tag array
//   ld_data    load strobe for the data array
//   mmem_read  line-fill request, held until mmem_resp
//   mmem_resp  one-cycle pulse: 256-bit mmem_rdata is valid this cycle
//   hit_cnt    requests answered without a fill (feature build only)
//   miss_cnt   COMPARE->FILL transitions (feature build only)
// -----------------------------------------------------------------------------
module i_cache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_read,
    output logic             cpu_resp,
    input  logic             hit,
    output logic             ld_v,
    output logic             ld_tag,
    output logic             ld_data,
    output logic             mmem_read,
    input  logic             mmem_resp
`ifdef I_CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        FILL    = 2'd2,
        UPDATE  = 2'd3
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   ld_line;

    // -------------------------------------------------------------------------
    // Next state and outputs.
    //
    // The outputs depend on the present state and on the current hit and
    // mmem_resp inputs. This is how a hit is answered in the cycle after
    // cpu_read is first seen, and how the line is loaded in the same cycle
    // that mmem_resp pulses. Registered outputs would add a cycle to both
    // paths. Because state_q resets asynchronously to IDLE, every output
    // goes low as soon as rst rises. An active fill is therefore dropped
    // at once.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement. This
        // means no path leaves a signal unassigned, so no latch is inferred.
        state_d   = state_q;
        cpu_resp  = 1'b0;
        mmem_read = 1'b0;
        ld_line   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_read) begin
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (!cpu_read) begin
                    // The request was withdrawn before a decision was made.
                    state_d = IDLE;
                end else if (hit) begin
                    cpu_resp = 1'b1;
                    state_d  = IDLE;
                end else begin
                    // Raise the fill request now, one cycle before FILL.
                    mmem_read = 1'b1;
                    state_d   = FILL;
                end
            end

            FILL: begin
                // The fill runs to completion even if cpu_read drops.
                mmem_read = 1'b1;
                if (mmem_resp) begin
                    ld_line = 1'b1;
                    state_d = UPDATE;
                end
            end

            UPDATE: begin
                // The line is now in the arrays. Re-check the tag in COMPARE
                // so that cache_rdata comes from the newly loaded line.
                state_d = cpu_read ? COMPARE : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The valid, tag and data arrays are always loaded together.
    assign ld_v    = ld_line;
    assign ld_tag  = ld_line;
    assign ld_data = ld_line;

    // NOTE: sequential state is written only with non-blocking assignments.
    // All flops then sample values from before the clock edge, so the
    // simulation result does not depend on the order of always blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef I_CACHE_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters.
    //
    // After a fill, the request is answered from COMPARE just like a hit.
    // A per-request flag records that this request went through FILL, so
    // its final cpu_resp is not counted as a hit. The flag is set on entry
    // to FILL and cleared whenever the FSM is in IDLE. Every completed or
    // abandoned request passes through IDLE, so the flag never carries over
    // to the next request.
    // -------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             fill_seen_q;
    logic             fill_seen_d;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] miss_cnt_d;
    logic             start_fill;

    assign start_fill = (state_q == COMPARE) && (state_d == FILL);

    always_comb begin
        fill_seen_d = fill_seen_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        if (state_q == IDLE) begin
            fill_seen_d = 1'b0;
        end else if (start_fill) begin
            fill_seen_d = 1'b1;
        end

        // Both counters stop at all-ones instead of wrapping to zero.
        if (cpu_resp && !fill_seen_q && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + CNT_ONE;
        end

        if (start_fill && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_seen_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            fill_seen_q <= fill_seen_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Interface invariants.
    // -------------------------------------------------------------------------
    a_resp_vs_fill : assert property (@(posedge clk) disable iff (rst)
        !(cpu_resp && mmem_read));

    a_ld_only_in_fill : assert property (@(posedge clk) disable iff (rst)
        (ld_v || ld_tag || ld_data) |-> (state_q == FILL));

    a_resp_needs_read : assert property (@(posedge clk) disable iff (rst)
        cpu_resp |-> cpu_read);

endmodule
